// File: rtl/sha256_host_seq.sv
// rtl/sha256_host_seq.sv - host sequencer: load message, run the SHA-256 engine, stream the digest
module sha256_host_seq #(
    parameter int          NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_BASE     = 16'h0000,
    parameter logic [15:0] OUT_BASE     = 16'h0100,
    parameter int          TIMEOUT      = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        err,
    output logic        busy,
    output logic        sha_start,
    input  logic        sha_done,
    output logic [15:0] message_addr,
    output logic [15:0] output_addr,
    output logic        eng_sel,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);
    localparam int         CW     = $clog2(TIMEOUT + 1);
    localparam logic [6:0] K_LAST = 7'(NUM_OF_WORDS - 1);

    typedef enum logic [2:0] {
        S_LOAD, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_RD_ADDR, S_RD_CAP, S_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [31:0]   out_data_q, out_data_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_LOAD;
            k_q         <= '0;
            cnt_q       <= '0;
            armed_q     <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            armed_q     <= 1'b1;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // armed_q keeps in_ready low for the first cycle after reset release
    assign in_ready     = armed_q && (state_q == S_LOAD);
    assign busy         = (state_q != S_LOAD);
    assign sha_start    = (state_q == S_START);
    assign eng_sel      = (state_q == S_START) || (state_q == S_WAIT_BUSY) ||
                          (state_q == S_WAIT_DONE);
    assign err          = err_q;
    assign out_valid    = out_valid_q;
    assign out_last     = out_last_q;
    assign out_data     = out_data_q;
    assign message_addr = MSG_BASE;
    assign output_addr  = OUT_BASE;

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        cnt_d          = cnt_q;
        err_d          = 1'b0;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        out_data_d     = out_data_q;
        mem_addr       = '0;
        mem_we         = 1'b0;
        mem_write_data = '0;
        case (state_q)
            S_LOAD: begin
                if (in_ready) begin
                    mem_addr       = MSG_BASE + 16'(k_q);
                    mem_write_data = in_data;
                    mem_we         = in_valid;
                    if (in_valid) begin
                        if (in_last && (k_q == K_LAST)) begin
                            state_d = S_START;
                            k_d     = '0;
                        end else if (in_last || (k_q == K_LAST)) begin
                            err_d = 1'b1;
                            k_d   = '0;
                        end else begin
                            k_d = k_q + 7'd1;
                        end
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_BUSY;
                cnt_d   = '0;
            end
            // done is still high the first cycle: the engine needs a cycle to leave IDLE
            S_WAIT_BUSY: begin
                if (!sha_done) begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_LOAD;
                    err_d   = 1'b1;
                    k_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (sha_done) begin
                    state_d = S_RD_ADDR;
                    k_d     = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_LOAD;
                    err_d   = 1'b1;
                    k_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RD_ADDR: begin
                mem_addr = OUT_BASE + 16'(k_q);
                state_d  = S_RD_CAP;
            end
            S_RD_CAP: begin
                out_data_d  = mem_read_data;
                out_valid_d = 1'b1;
                out_last_d  = (k_q == 7'd7);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (k_q == 7'd7) begin
                        state_d = S_LOAD;
                        k_d     = '0;
                    end else begin
                        state_d = S_RD_ADDR;
                        k_d     = k_q + 7'd1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end
endmodule

// File: tb/tb_sha256_host_seq.sv
// tb/tb_sha256_host_seq.sv - directed bench for sha256_host_seq with a stub engine and memory
module tb_sha256_host_seq;
    localparam int NW       = 20;
    localparam int TO       = 64;
    localparam int ENG_BUSY = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_last;
    logic        err;
    logic        busy;
    logic        sha_start;
    logic        sha_done = 1'b1;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic        eng_sel;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    sha256_host_seq #(
        .NUM_OF_WORDS(NW), .MSG_BASE(16'h0000), .OUT_BASE(16'h0100), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .err(err), .busy(busy), .sha_start(sha_start), .sha_done(sha_done),
        .message_addr(message_addr), .output_addr(output_addr), .eng_sel(eng_sel),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Shared memory plus stub engine: done drops the cycle after start, digest written on completion
    logic [31:0] mem [0:511];
    logic [31:0] rd_q;
    logic        eng_run = 1'b0;
    logic        eng_hang = 1'b0;
    int          eng_cnt = 0;
    assign mem_read_data = rd_q;

    always @(posedge clk) begin
        if (mem_we && !eng_sel) mem[mem_addr[8:0]] <= mem_write_data;
        rd_q <= mem[mem_addr[8:0]];
        if (!reset_n) begin
            sha_done <= 1'b1;
            eng_run  <= 1'b0;
            eng_cnt  <= 0;
        end else if (sha_start && eng_sel) begin
            sha_done <= 1'b0;
            eng_run  <= 1'b1;
            eng_cnt  <= 0;
            for (int i = 0; i < 8; i++) mem[256 + i] <= 32'hDEAD0000;
        end else if (eng_run && !eng_hang) begin
            if (eng_cnt == ENG_BUSY - 1) begin
                for (int i = 0; i < 8; i++) mem[256 + i] <= 32'hA0000000 + 32'(i);
                sha_done <= 1'b1;
                eng_run  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    int          cyc = 0;
    int          err_cnt = 0;
    int          start_cnt = 0;
    int          start_cyc = 0;
    logic [32:0] outq[$];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (err) err_cnt++;
            if (sha_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (out_valid && out_ready) outq.push_back({out_last, out_data});
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int  t;
        logic got;
        t = 0;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!got) begin
            @(negedge clk);
            got = in_ready;
            tick();
            t++;
            if (!got && t > 200) begin
                chk("in_ready_wait", 64'(0), 64'(1));
                got = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input int last_at);
        for (int k = 0; k < n; k++) send_word(base + 32'(k), k == last_at);
    endtask

    task automatic wait_digest(input string name);
        int t;
        t = 0;
        while (outq.size() < 8 && t < 600) begin
            @(negedge clk);
            t++;
        end
        chk(name, 64'(outq.size()), 64'(8));
    endtask

    task automatic check_digest(input string name);
        for (int i = 0; i < 8 && i < outq.size(); i++)
            chk(name, 64'(outq[i]), 64'({i == 7, 32'hA0000000 + 32'(i)}));
    endtask

    task automatic check_msg(input string name, input logic [31:0] base);
        int bad;
        bad = 0;
        for (int k = 0; k < NW; k++) if (mem[k] !== base + 32'(k)) bad++;
        chk(name, 64'(bad), 64'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 64'({in_ready, out_valid, out_last, err, busy, sha_start, eng_sel, mem_we}), 64'(0));
        chk(name, 64'({out_data, mem_write_data}), 64'(0));
        chk(name, 64'(mem_addr), 64'(0));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("in_ready_first_cycle", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("in_ready_armed", 64'(in_ready), 64'(1));
        tick();
    endtask

    task automatic accept_word(input string name, input int idx);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 300);
        chk(name, 64'(out_valid), 64'(1));
        if (idx == 3) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                chk("bp_stable", 64'({out_valid, out_last, out_data}), 64'({2'b10, 32'hA0000003}));
            end
        end
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        int          n;
        int          last_at;
        int          exp_err;
        int          exp_start;
    } vec_t;

    vec_t vt[5];

    initial begin
        int e0, s0, t;
        vt[0] = '{32'h01234675, 20, 19, 0, 1};
        vt[1] = '{32'h11110000, 6, 5, 1, 0};
        vt[2] = '{32'h22220000, 20, 19, 0, 1};
        vt[3] = '{32'h33330000, 20, -1, 1, 0};
        vt[4] = '{32'h44440000, 20, 19, 0, 1};

        #3;
        check_reset_outputs("reset_state");
        chk("const_addrs", 64'({message_addr, output_addr}), 64'({16'h0000, 16'h0100}));
        repeat (2) tick();
        release_reset();

        for (int v = 0; v < 5; v++) begin
            e0 = err_cnt;
            s0 = start_cnt;
            outq.delete();
            send_frame(vt[v].base, vt[v].n, vt[v].last_at);
            if (vt[v].exp_start != 0) begin
                wait_digest("digest_count");
                check_digest("digest_word");
                check_msg("msg_mem", vt[v].base);
                repeat (2) tick();
            end else begin
                repeat (5) tick();
                @(negedge clk);
                chk("in_ready_after_err", 64'(in_ready), 64'(1));
                tick();
            end
            chk("err_pulses", 64'(err_cnt - e0), 64'(vt[v].exp_err));
            chk("start_pulses", 64'(start_cnt - s0), 64'(vt[v].exp_start));
        end

        // output backpressure: word 3 held for 10 cycles
        out_ready = 1'b0;
        outq.delete();
        send_frame(32'h55550000, NW, NW - 1);
        for (int i = 0; i < 8; i++) accept_word("bp_valid", i);
        chk("bp_count", 64'(outq.size()), 64'(8));
        check_digest("bp_word");
        out_ready = 1'b1;
        repeat (2) tick();

        // engine never completes: timeout back to LOAD
        eng_hang = 1'b1;
        e0 = err_cnt;
        send_frame(32'h66660000, NW, NW - 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!err && t < 300);
        chk("to_err_seen", 64'(err), 64'(1));
        chk("to_delay", 64'(cyc - start_cyc), 64'(TO + 2));
        chk("to_state", 64'({eng_sel, in_ready, busy}), 64'(3'b010));
        tick();
        chk("to_err_pulses", 64'(err_cnt - e0), 64'(1));
        reset_n = 1'b0;
        repeat (3) tick();
        eng_hang = 1'b0;
        release_reset();

        // reset while digest word 4 is presented
        out_ready = 1'b0;
        send_frame(32'h77770000, NW, NW - 1);
        for (int i = 0; i < 4; i++) accept_word("rst_pre_valid", i);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 300);
        chk("rst_word4", 64'({out_valid, out_data}), 64'({1'b1, 32'hA0000004}));
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        out_ready = 1'b1;
        repeat (3) tick();
        release_reset();
        e0 = err_cnt;
        s0 = start_cnt;
        outq.delete();
        send_frame(32'h88880000, NW, NW - 1);
        wait_digest("post_rst_count");
        check_digest("post_rst_word");
        check_msg("post_rst_msg", 32'h88880000);
        chk("post_rst_err", 64'(err_cnt - e0), 64'(0));
        chk("post_rst_start", 64'(start_cnt - s0), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
